pipeline_stage_latch_hs: RTL and testbench
==========================================

Name: pipeline_stage_latch_hs

Overview:
- Parametrised successor to the fixed stage-to-stage pipeline latches in the 64-bit datapath; carries the dbus, bbus, Dselect, lwSw, branch-control and NOP fields between adjacent stages.
- Adds what the fixed latches lack: async reset, valid/ready handshake with a 2-entry skid buffer for full-throughput back-pressure, synchronous flush for branch squash, bubble insertion and a saturating stall counter.
- Slots between any two stages wherever a downstream stall or branch flush must be absorbed.

Parameters:
DATA_W, 64, width of dbus and bbus fields
SEL_W, 32, width of one-hot Dselect destination field
LS_W, 2, width of lwSw flag field
BR_W, 3, width of branch-control field
CNT_W, 16, width of stall counter

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-high; clears all state
in_valid  input  1  upstream beat present
in_ready  output  1  latch can accept a beat this cycle (registered)
dbus_in  input  DATA_W  ALU/result bus in
bbus_in  input  DATA_W  store-data bus in
dselect_in  input  SEL_W  one-hot destination register select in
lwsw_in  input  LS_W  load/store flag in
brctl_in  input  BR_W  branch-control bits in
nop_in  input  1  beat is an architectural NOP
flush  input  1  synchronous squash of all held beats
out_valid  output  1  output beat present
out_ready  input  1  downstream accepts beat
dbus_out  output  DATA_W  dbus out
bbus_out  output  DATA_W  bbus out
dselect_out  output  SEL_W  destination select out
lwsw_out  output  LS_W  load/store flag out
brctl_out  output  BR_W  branch-control out
nop_out  output  1  NOP flag out
stall_cnt  output  CNT_W  saturating count of stalled cycles

Behaviour:
- Storage: main entry (drives outputs) and skid entry; each has a valid bit.
- Reset (async, immediate): main_valid=0, skid_valid=0, in_ready=1, all data fields 0, stall_cnt=0.
- Accept: in_valid & in_ready. Deliver: out_valid & out_ready.
- out_valid = main_valid. in_ready = !skid_valid, registered (no combinational path from out_ready).
- Main load condition: !main_valid or deliver. On load, main takes the skid entry if skid_valid, else the input beat if accepted, else main_valid goes to 0.
- Skid load: accept while main is valid and not delivering -> beat goes to skid; next cycle in_ready=0.
- Skid drains into main on the first deliver; in_ready returns to 1 the following cycle.
- Ordering strictly FIFO; no beat dropped or duplicated except by flush.
- Latency: accept at edge N -> out_valid at edge N (visible in cycle N+1) when empty. Sustained throughput 1 beat/cycle with out_ready held high.
- Bubble output: while out_valid=0, dselect_out=0 and nop_out=1 (no register write downstream); other fields hold last value.
- nop_in beats are normal beats; all fields pass unchanged.
- Flush: at the next edge main_valid=0, skid_valid=0, in_ready=1. A beat accepted in the flush cycle is discarded. Flush wins over simultaneous accept/deliver; the deliver handshake still completes downstream in that cycle.
- stall_cnt: +1 each cycle out_valid & !out_ready; saturates at 2^CNT_W-1; cleared only by reset.
- Fields are captured exactly at width; no truncation or extension.
- Reset mid-transfer: all beats lost, outputs show bubble immediately.

Test Plan:
- Reset asserted mid-stream with both entries full -> out_valid=0, dselect_out=0, nop_out=1, in_ready=1, stall_cnt=0 without a clock edge.
- Stream 8 beats (dbus_in=1..8, dselect_in=1<<k), out_ready=1 -> out_valid 1 cycle after the first accept; beats 1..8 emerge back-to-back in order; stall_cnt=0.
- Send beats A,B with out_ready=0 -> A in main, B in skid, in_ready=0; hold 5 cycles -> stall_cnt=5; raise out_ready -> A then B delivered, in_ready=1 one cycle after A leaves.
- Full latch plus flush with in_valid=1 (beat C) -> next cycle out_valid=0, in_ready=1, C never appears; the next beat D appears normally.
- out_ready=0 for 2^CNT_W+3 cycles with CNT_W=4 -> stall_cnt sticks at 15.
- Random in_valid/out_ready/flush for 10k cycles against a scoreboard model -> output sequence matches the model exactly; no handshake-rule violation.

Source files
------------

// File: rtl/pipeline_stage_latch_hs.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_stage_latch_hs
// Purpose  : Stage-to-stage pipeline latch for the 64-bit datapath. It carries
//            the dbus, bbus, Dselect, lwSw, branch-control and NOP fields
//            between adjacent stages. It adds a valid/ready handshake with a
//            2-entry skid buffer, so the latch sustains full throughput under
//            back-pressure. It also provides a synchronous flush for branch
//            squash, bubble insertion on empty cycles, and a saturating
//            stall counter.
// Ports    :
//   clk          rising-edge clock
//   reset        asynchronous active-high reset, clears all state
//   in_valid     upstream beat present
//   in_ready     latch can accept a beat this cycle (registered)
//   *_in         beat fields in (dbus, bbus, dselect, lwsw, brctl, nop)
//   flush        synchronous squash of every held beat
//   out_valid    output beat present
//   out_ready    downstream accepts the beat
//   *_out        beat fields out
//   stall_cnt    saturating count of cycles with out_valid & !out_ready
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_stage_latch_hs #(
    parameter int DATA_W = 64,
    parameter int SEL_W  = 32,
    parameter int LS_W   = 2,
    parameter int BR_W   = 3,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    // upstream side
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] dbus_in,
    input  logic [DATA_W-1:0] bbus_in,
    input  logic [SEL_W-1:0]  dselect_in,
    input  logic [LS_W-1:0]   lwsw_in,
    input  logic [BR_W-1:0]   brctl_in,
    input  logic              nop_in,
    // control
    input  logic              flush,
    // downstream side
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] dbus_out,
    output logic [DATA_W-1:0] bbus_out,
    output logic [SEL_W-1:0]  dselect_out,
    output logic [LS_W-1:0]   lwsw_out,
    output logic [BR_W-1:0]   brctl_out,
    output logic              nop_out,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // ------------------------------------------------------------------
    // Main entry (drives the outputs)
    // ------------------------------------------------------------------
    logic              main_valid_q, main_valid_d;
    logic [DATA_W-1:0] main_dbus_q,  main_dbus_d;
    logic [DATA_W-1:0] main_bbus_q,  main_bbus_d;
    logic [SEL_W-1:0]  main_dsel_q,  main_dsel_d;
    logic [LS_W-1:0]   main_lwsw_q,  main_lwsw_d;
    logic [BR_W-1:0]   main_brctl_q, main_brctl_d;
    logic              main_nop_q,   main_nop_d;

    // ------------------------------------------------------------------
    // Skid entry (holds the beat accepted while main is stalled)
    // ------------------------------------------------------------------
    logic              skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0] skid_dbus_q,  skid_dbus_d;
    logic [DATA_W-1:0] skid_bbus_q,  skid_bbus_d;
    logic [SEL_W-1:0]  skid_dsel_q,  skid_dsel_d;
    logic [LS_W-1:0]   skid_lwsw_q,  skid_lwsw_d;
    logic [BR_W-1:0]   skid_brctl_q, skid_brctl_d;
    logic              skid_nop_q,   skid_nop_d;

    logic              in_ready_q,   in_ready_d;
    logic [CNT_W-1:0]  stall_cnt_q,  stall_cnt_d;

    // Handshake terms
    logic w_accept;
    logic w_deliver;
    logic w_main_load;

    assign w_accept    = in_valid & in_ready_q;
    assign w_deliver   = main_valid_q & out_ready;
    // Main may take a new beat when it is empty or its beat leaves this cycle
    assign w_main_load = !main_valid_q | w_deliver;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        main_valid_d = main_valid_q;
        main_dbus_d  = main_dbus_q;
        main_bbus_d  = main_bbus_q;
        main_dsel_d  = main_dsel_q;
        main_lwsw_d  = main_lwsw_q;
        main_brctl_d = main_brctl_q;
        main_nop_d   = main_nop_q;

        skid_valid_d = skid_valid_q;
        skid_dbus_d  = skid_dbus_q;
        skid_bbus_d  = skid_bbus_q;
        skid_dsel_d  = skid_dsel_q;
        skid_lwsw_d  = skid_lwsw_q;
        skid_brctl_d = skid_brctl_q;
        skid_nop_d   = skid_nop_q;

        if (flush) begin
            // Squash everything. Data fields hold so the bubble keeps showing
            // the last values. Any beat accepted this cycle is dropped.
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (w_main_load) begin
            if (skid_valid_q) begin
                // Drain the older skid beat first to keep FIFO order. in_ready
                // is low while skid is full, so no accept can collide here.
                main_valid_d = 1'b1;
                main_dbus_d  = skid_dbus_q;
                main_bbus_d  = skid_bbus_q;
                main_dsel_d  = skid_dsel_q;
                main_lwsw_d  = skid_lwsw_q;
                main_brctl_d = skid_brctl_q;
                main_nop_d   = skid_nop_q;
                skid_valid_d = 1'b0;
            end else if (w_accept) begin
                main_valid_d = 1'b1;
                main_dbus_d  = dbus_in;
                main_bbus_d  = bbus_in;
                main_dsel_d  = dselect_in;
                main_lwsw_d  = lwsw_in;
                main_brctl_d = brctl_in;
                main_nop_d   = nop_in;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (w_accept) begin
            // Main is full and stalled: park the incoming beat in skid
            skid_valid_d = 1'b1;
            skid_dbus_d  = dbus_in;
            skid_bbus_d  = bbus_in;
            skid_dsel_d  = dselect_in;
            skid_lwsw_d  = lwsw_in;
            skid_brctl_d = brctl_in;
            skid_nop_d   = nop_in;
        end

        // Ready is registered off the next skid state, so there is no
        // combinational path from out_ready back to in_ready.
        in_ready_d = !skid_valid_d;

        stall_cnt_d = stall_cnt_q;
        if (main_valid_q && !out_ready && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_valid_q <= 1'b0;
            main_dbus_q  <= '0;
            main_bbus_q  <= '0;
            main_dsel_q  <= '0;
            main_lwsw_q  <= '0;
            main_brctl_q <= '0;
            main_nop_q   <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_dbus_q  <= '0;
            skid_bbus_q  <= '0;
            skid_dsel_q  <= '0;
            skid_lwsw_q  <= '0;
            skid_brctl_q <= '0;
            skid_nop_q   <= 1'b0;
            in_ready_q   <= 1'b1;
            stall_cnt_q  <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_dbus_q  <= main_dbus_d;
            main_bbus_q  <= main_bbus_d;
            main_dsel_q  <= main_dsel_d;
            main_lwsw_q  <= main_lwsw_d;
            main_brctl_q <= main_brctl_d;
            main_nop_q   <= main_nop_d;
            skid_valid_q <= skid_valid_d;
            skid_dbus_q  <= skid_dbus_d;
            skid_bbus_q  <= skid_bbus_d;
            skid_dsel_q  <= skid_dsel_d;
            skid_lwsw_q  <= skid_lwsw_d;
            skid_brctl_q <= skid_brctl_d;
            skid_nop_q   <= skid_nop_d;
            in_ready_q   <= in_ready_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs. An empty latch presents a bubble: no destination select and
    // the NOP flag set, so nothing downstream writes a register.
    // ------------------------------------------------------------------
    assign in_ready    = in_ready_q;
    assign out_valid   = main_valid_q;
    assign dbus_out    = main_dbus_q;
    assign bbus_out    = main_bbus_q;
    assign dselect_out = main_valid_q ? main_dsel_q : '0;
    assign lwsw_out    = main_lwsw_q;
    assign brctl_out   = main_brctl_q;
    assign nop_out     = main_valid_q ? main_nop_q : 1'b1;
    assign stall_cnt   = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_stage_latch_hs.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_stage_latch_hs
// Purpose  : Directed and randomised checks of pipeline_stage_latch_hs with a
//            4-bit stall counter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_stage_latch_hs;

    localparam int DATA_W = 64;
    localparam int SEL_W  = 32;
    localparam int LS_W   = 2;
    localparam int BR_W   = 3;
    localparam int CNT_W  = 4;

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] dbus_in;
    logic [DATA_W-1:0] bbus_in;
    logic [SEL_W-1:0]  dselect_in;
    logic [LS_W-1:0]   lwsw_in;
    logic [BR_W-1:0]   brctl_in;
    logic              nop_in;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] dbus_out;
    logic [DATA_W-1:0] bbus_out;
    logic [SEL_W-1:0]  dselect_out;
    logic [LS_W-1:0]   lwsw_out;
    logic [BR_W-1:0]   brctl_out;
    logic              nop_out;
    logic [CNT_W-1:0]  stall_cnt;

    int n_tests;
    int n_fail;

    pipeline_stage_latch_hs #(
        .DATA_W (DATA_W),
        .SEL_W  (SEL_W),
        .LS_W   (LS_W),
        .BR_W   (BR_W),
        .CNT_W  (CNT_W)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dbus_in     (dbus_in),
        .bbus_in     (bbus_in),
        .dselect_in  (dselect_in),
        .lwsw_in     (lwsw_in),
        .brctl_in    (brctl_in),
        .nop_in      (nop_in),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .dbus_out    (dbus_out),
        .bbus_out    (bbus_out),
        .dselect_out (dselect_out),
        .lwsw_out    (lwsw_out),
        .brctl_out   (brctl_out),
        .nop_out     (nop_out),
        .stall_cnt   (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_beat(input logic [63:0] d, input logic [31:0] sel);
        in_valid   = 1'b1;
        dbus_in    = d;
        bbus_in    = ~d;
        dselect_in = sel;
        lwsw_in    = d[1:0];
        brctl_in   = d[2:0];
        nop_in     = d[3];
    endtask

    task automatic idle_in();
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    // Scoreboard for the random phase
    logic [63:0] q[$];
    logic [63:0] tag_ctr;

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "timeout");
    end

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        reset      = 1'b1;
        in_valid   = 1'b0;
        dbus_in    = '0;
        bbus_in    = '0;
        dselect_in = '0;
        lwsw_in    = '0;
        brctl_in   = '0;
        nop_in     = 1'b0;
        flush      = 1'b0;
        out_ready  = 1'b0;
        #1;
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_in_ready",  64'(in_ready),  64'd1);
        check_eq("rst_dbus",      dbus_out,       64'd0);
        tick();
        reset = 1'b0;
        tick();

        // ---------------- Reset mid-stream with both entries full ----------
        out_ready = 1'b0;
        drive_beat(64'hAAAA, 32'h4);
        tick();
        drive_beat(64'hBBBB, 32'h8);
        tick();
        idle_in();
        check_eq("full_in_ready",  64'(in_ready),  64'd0);
        check_eq("full_out_valid", 64'(out_valid), 64'd1);
        check_eq("full_dsel",      64'(dselect_out), 64'h4);
        #2;
        reset = 1'b1;
        #1;
        check_eq("amid_out_valid", 64'(out_valid),   64'd0);
        check_eq("amid_dsel",      64'(dselect_out), 64'd0);
        check_eq("amid_nop",       64'(nop_out),     64'd1);
        check_eq("amid_in_ready",  64'(in_ready),    64'd1);
        check_eq("amid_stall",     64'(stall_cnt),   64'd0);
        tick();
        reset = 1'b0;
        tick();

        // ---------------- Stream 8 beats at full rate ----------------------
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            drive_beat(64'(k + 1), 32'(1) << k);
            tick();
            check_eq("strm_valid", 64'(out_valid),   64'd1);
            check_eq("strm_dbus",  dbus_out,         64'(k + 1));
            check_eq("strm_dsel",  64'(dselect_out), 64'(32'(1) << k));
        end
        idle_in();
        tick();
        check_eq("strm_end_valid", 64'(out_valid),   64'd0);
        check_eq("strm_bub_dsel",  64'(dselect_out), 64'd0);
        check_eq("strm_bub_nop",   64'(nop_out),     64'd1);
        check_eq("strm_hold_dbus", dbus_out,         64'd8);
        check_eq("strm_stall",     64'(stall_cnt),   64'd0);

        // ---------------- Back-pressure: A in main, B in skid --------------
        do_reset();
        out_ready = 1'b0;
        drive_beat(64'h1234_0000_0000_00A0, 32'h10);
        tick();
        drive_beat(64'h5678_0000_0000_00B8, 32'h20);
        tick();
        idle_in();
        check_eq("bp_in_ready", 64'(in_ready), 64'd0);
        check_eq("bp_dbus_a",   dbus_out,      64'h1234_0000_0000_00A0);
        check_eq("bp_bbus_a",   bbus_out,      ~64'h1234_0000_0000_00A0);
        for (int i = 0; i < 4; i++) tick();
        check_eq("bp_stall5", 64'(stall_cnt), 64'd5);
        out_ready = 1'b1;
        #1;
        check_eq("bp_deliver_a", dbus_out, 64'h1234_0000_0000_00A0);
        tick();
        check_eq("bp_valid_b",  64'(out_valid),   64'd1);
        check_eq("bp_dbus_b",   dbus_out,         64'h5678_0000_0000_00B8);
        check_eq("bp_dsel_b",   64'(dselect_out), 64'h20);
        check_eq("bp_nop_b",    64'(nop_out),     64'd1);
        check_eq("bp_brctl_b",  64'(brctl_out),   64'd0);
        check_eq("bp_lwsw_b",   64'(lwsw_out),    64'd0);
        check_eq("bp_ready_up", 64'(in_ready),    64'd1);
        check_eq("bp_stall_hold", 64'(stall_cnt), 64'd5);
        tick();
        check_eq("bp_empty", 64'(out_valid), 64'd0);

        // ---------------- Flush with full latch and beat C -----------------
        do_reset();
        out_ready = 1'b0;
        drive_beat(64'h11, 32'h1);
        tick();
        drive_beat(64'h22, 32'h2);
        tick();
        drive_beat(64'hCC, 32'h4);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        idle_in();
        check_eq("fl_out_valid", 64'(out_valid),   64'd0);
        check_eq("fl_in_ready",  64'(in_ready),    64'd1);
        check_eq("fl_dsel",      64'(dselect_out), 64'd0);
        tick();
        check_eq("fl_no_c", 64'(out_valid), 64'd0);
        out_ready = 1'b1;
        drive_beat(64'hDD, 32'h8);
        tick();
        idle_in();
        check_eq("fl_d_valid", 64'(out_valid), 64'd1);
        check_eq("fl_d_dbus",  dbus_out,       64'hDD);
        tick();
        check_eq("fl_d_gone", 64'(out_valid), 64'd0);
        // Flush on an empty latch discards a beat accepted in the same cycle
        drive_beat(64'hEE, 32'h1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        idle_in();
        check_eq("fl_acc_drop", 64'(out_valid), 64'd0);

        // ---------------- Stall counter saturation -------------------------
        do_reset();
        out_ready = 1'b0;
        drive_beat(64'h77, 32'h1);
        tick();
        idle_in();
        for (int i = 0; i < (1 << CNT_W) + 3; i++) tick();
        check_eq("sat_stall", 64'(stall_cnt), 64'd15);
        check_eq("sat_dbus",  dbus_out,       64'h77);

        // ---------------- Random traffic against a FIFO scoreboard ---------
        do_reset();
        q.delete();
        tag_ctr = 64'h100;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            logic acc;
            logic dlv;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            if (in_valid) drive_beat(tag_ctr, 32'(1) << tag_ctr[4:0]);
            #1;
            check_eq("rnd_out_valid", 64'(out_valid), 64'(q.size() > 0));
            check_eq("rnd_in_ready",  64'(in_ready),  64'(q.size() < 2));
            acc = in_valid && (q.size() < 2);
            dlv = out_ready && (q.size() > 0);
            if (dlv) begin
                check_eq("rnd_dbus", dbus_out, q[0]);
                check_eq("rnd_dsel", 64'(dselect_out), 64'(32'(1) << q[0][4:0]));
                void'(q.pop_front());
            end
            if (flush) begin
                q.delete();
            end else if (acc) begin
                q.push_back(tag_ctr);
            end
            if (acc) tag_ctr = tag_ctr + 1;
            @(posedge clk);
            #1;
        end
        flush    = 1'b0;
        in_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
